// File: rtl/multicycle_core_if.sv
// Instruction and data memory buses of the multicycle core.
// The core drives the master side; memories sit on the slave side.
interface multicycle_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [7:0]            imem_rdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_core.sv
// Four-register multicycle core: FETCH/DECODE/EXECUTE/MEM/WB/HALT with
// req/ack instruction and data memories and a sticky signed-overflow flag.
module multicycle_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_core_if.master     bus,
  output logic                  retire,
  output logic                  halted,
  output logic                  ovf,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic [1:0]            dbg_sel,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011,
                         OP_OR  = 4'b0100, OP_SLT = 4'b0101, OP_LW  = 4'b1010,
                         OP_SW  = 4'b1011, OP_BEQ = 4'b1100, OP_BNE = 4'b1101,
                         OP_J   = 4'b1110;
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            ir;
  logic [DATA_WIDTH-1:0] rf [4];
  logic [DATA_WIDTH-1:0] a, b, res;
  logic [DATA_WIDTH-1:0] sum, diff, alu_res;
  logic                  alu_ovf;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr, r0_addr, pc_inc, pc_nxt;

  wire [3:0] op = ir[7:4];
  wire [1:0] rs = ir[3:2];
  wire [1:0] rt = ir[1:0];

  wire is_alu = (op >= OP_ADD) && (op <= OP_SLT);
  wire is_mem = (op == OP_LW) || (op == OP_SW);

  // Register values used as addresses are truncated or zero-extended to ADDR_WIDTH.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_addr_trunc
      assign a_addr  = a[ADDR_WIDTH-1:0];
      assign b_addr  = b[ADDR_WIDTH-1:0];
      assign r0_addr = rf[0][ADDR_WIDTH-1:0];
    end else begin : g_addr_ext
      assign a_addr  = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, a};
      assign b_addr  = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, b};
      assign r0_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, rf[0]};
    end
  endgenerate

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  assign pc_inc = pc + ADDR_WIDTH'(1);

  always_comb begin
    pc_nxt = pc_inc;
    case (op)
      OP_BEQ:  if (a == b) pc_nxt = pc_inc + r0_addr;
      OP_BNE:  if (a != b) pc_nxt = pc_inc + r0_addr;
      OP_J:    pc_nxt = a_addr;
      default: pc_nxt = pc_inc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   if (bus.imem_ack) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = (ir == 8'h00) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM:     if (bus.dmem_ack) state_nxt = S_WB;
      S_WB:      state_nxt = S_FETCH;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Acks are only honoured in their own state, so stray acks never change state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= ADDR_WIDTH'(RESET_PC);
      ir  <= 8'h00;
      a   <= '0;
      b   <= '0;
      res <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH:   if (bus.imem_ack) ir <= bus.imem_rdata;
        S_DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
        end
        S_EXECUTE: begin
          res <= alu_res;
          if (alu_ovf) ovf <= 1'b1;
        end
        S_MEM:     if (bus.dmem_ack && op == OP_LW) res <= bus.dmem_rdata;
        S_WB: begin
          if (is_alu || op == OP_LW) rf[rs] <= res;
          pc <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && (op == OP_SW);
  assign bus.dmem_addr  = b_addr;
  assign bus.dmem_wdata = a;
  assign retire         = (state == S_WB);
  assign halted         = (state == S_HALT);
  assign dbg_data       = rf[dbg_sel];
endmodule
